harness_cmd_sequencer: RTL

Synthesizable command sequencer that drives a wrapped DUT from a byte-oriented command stream, for emulation and FPGA-hosted test. It uses the same command byte set as the simulation harness. It owns the DUT's reset, clock-enable and input vector. On request it returns the DUT output vector as 32-bit words over a valid/ready response stream.

---
 rtl/harness_cmd_sequencer_if.sv | 22 ++
 rtl/harness_cmd_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/harness_cmd_sequencer_if.sv
// Command/response stream bundle for harness_cmd_sequencer.
//   cmd_data/cmd_valid/cmd_ready : byte command stream into the sequencer
//   rsp_data/rsp_valid/rsp_ready : 32-bit response word stream out of it
// master = host side, slave = sequencer side.
interface harness_cmd_sequencer_if;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;

  modport master (
    output cmd_data, cmd_valid, rsp_ready,
    input  cmd_ready, rsp_data, rsp_valid
  );

  modport slave (
    input  cmd_data, cmd_valid, rsp_ready,
    output cmd_ready, rsp_data, rsp_valid
  );
endinterface

// File: rtl/harness_cmd_sequencer.sv
// Byte-command sequencer that owns a wrapped DUT's reset, clock enable and
// input vector, and returns the DUT output vector as 32-bit response words.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   cmd_rsp      : command byte stream in / response word stream out
//   dut_in_o     : DUT input vector (updated atomically after a full LOAD)
//   dut_rst_o    : DUT reset, active-high
//   dut_ce_o     : DUT clock enable
//   dut_out_i    : DUT output vector
//   done_o       : halt command received
//   err_o        : illegal command received, err_code_o holds the byte
// Optional feature macro STEP_COUNT_EN: adds step_count_o (count of dut_ce
// cycles) and appends it as the final word of every dump.
module harness_cmd_sequencer #(
  parameter int unsigned INPUT_BYTES  = 4,
  parameter int unsigned OUTPUT_WORDS = 2,
  parameter int unsigned STEP_CYCLES  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  harness_cmd_sequencer_if.slave      cmd_rsp,
  output logic [INPUT_BYTES*8-1:0]    dut_in_o,
  output logic                        dut_rst_o,
  output logic                        dut_ce_o,
  input  logic [OUTPUT_WORDS*32-1:0]  dut_out_i,
  output logic                        done_o,
  output logic                        err_o,
  output logic [7:0]                  err_code_o
`ifdef STEP_COUNT_EN
  ,
  output logic [31:0]                 step_count_o
`endif
);

  localparam int unsigned IN_W = INPUT_BYTES * 8;
`ifdef STEP_COUNT_EN
  localparam int unsigned RSP_WORDS = OUTPUT_WORDS + 1;
`else
  localparam int unsigned RSP_WORDS = OUTPUT_WORDS;
`endif
  localparam int unsigned SNAP_W     = RSP_WORDS * 32;
  localparam int unsigned LOAD_CNT_W = $clog2(INPUT_BYTES + 1);
  localparam int unsigned STEP_CNT_W = $clog2(STEP_CYCLES + 1);
  localparam int unsigned DUMP_CNT_W = $clog2(RSP_WORDS + 1);

  localparam logic [7:0] CMD_DUMP    = 8'h68;
  localparam logic [7:0] CMD_HALT    = 8'h69;
  localparam logic [7:0] CMD_RST_ON  = 8'h6A;
  localparam logic [7:0] CMD_RST_OFF = 8'h6B;
  localparam logic [7:0] CMD_STEP    = 8'h6C;
  localparam logic [7:0] CMD_LOAD    = 8'h6D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STEP,
    ST_DUMP,
    ST_HALT,
    ST_ERR
  } state_t;

  state_t                 state_q, state_d;
  logic [IN_W-1:0]        shadow_q, shadow_d;
  logic [LOAD_CNT_W-1:0]  load_cnt_q, load_cnt_d;
  logic [STEP_CNT_W-1:0]  step_cnt_q, step_cnt_d;
  logic [DUMP_CNT_W-1:0]  dump_cnt_q, dump_cnt_d;
  logic [SNAP_W-1:0]      snap_q, snap_d;
  logic [IN_W-1:0]        dut_in_q, dut_in_d;
  logic                   dut_rst_q, dut_rst_d;
  logic                   dut_ce_q, dut_ce_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [31:0]            rsp_data_q, rsp_data_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [7:0]             err_code_q, err_code_d;
`ifdef STEP_COUNT_EN
  logic [31:0]            step_count_q, step_count_d;
`endif

  logic                   cmd_ready_c;
  logic                   cmd_fire_c;
  logic                   rsp_fire_c;
  logic [IN_W+7:0]        load_cat_c;
  logic [IN_W-1:0]        load_shift_c;
  logic [SNAP_W-1:0]      snap_src_c;
  logic [SNAP_W-1:0]      snap_shift_c;

  // Ready is a pure function of state so the host sees it without a cycle of lag.
  assign cmd_ready_c = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign cmd_fire_c  = cmd_rsp.cmd_valid && cmd_ready_c;
  assign rsp_fire_c  = rsp_valid_q && cmd_rsp.rsp_ready;

  // New byte enters at the top; after INPUT_BYTES bytes the first one sits in the LSBs.
  assign load_cat_c   = {cmd_rsp.cmd_data, shadow_q};
  assign load_shift_c = load_cat_c[IN_W+7:8];

`ifdef STEP_COUNT_EN
  assign snap_src_c = {step_count_q, dut_out_i};
`else
  assign snap_src_c = dut_out_i;
`endif
  // Dump walks the snapshot by shifting the next word into the low 32 bits.
  assign snap_shift_c = snap_q >> 32;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      shadow_q     <= '0;
      load_cnt_q   <= '0;
      step_cnt_q   <= '0;
      dump_cnt_q   <= '0;
      snap_q       <= '0;
      dut_in_q     <= '0;
      dut_rst_q    <= 1'b1;
      dut_ce_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= '0;
`ifdef STEP_COUNT_EN
      step_count_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      load_cnt_q   <= load_cnt_d;
      step_cnt_q   <= step_cnt_d;
      dump_cnt_q   <= dump_cnt_d;
      snap_q       <= snap_d;
      dut_in_q     <= dut_in_d;
      dut_rst_q    <= dut_rst_d;
      dut_ce_q     <= dut_ce_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
`ifdef STEP_COUNT_EN
      step_count_q <= step_count_d;
`endif
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    load_cnt_d  = load_cnt_q;
    step_cnt_d  = step_cnt_q;
    dump_cnt_d  = dump_cnt_q;
    snap_d      = snap_q;
    dut_in_d    = dut_in_q;
    dut_rst_d   = dut_rst_q;
    dut_ce_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    done_d      = done_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
`ifdef STEP_COUNT_EN
    step_count_d = dut_ce_q ? step_count_q + 32'd1 : step_count_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire_c) begin
          case (cmd_rsp.cmd_data)
            CMD_DUMP: begin
              state_d     = ST_DUMP;
              snap_d      = snap_src_c;
              rsp_valid_d = 1'b1;
              rsp_data_d  = snap_src_c[31:0];
              dump_cnt_d  = '0;
            end
            CMD_HALT: begin
              state_d = ST_HALT;
              done_d  = 1'b1;
            end
            CMD_RST_ON: begin
              dut_rst_d = 1'b1;
`ifdef STEP_COUNT_EN
              step_count_d = '0;
`endif
            end
            CMD_RST_OFF: begin
              dut_rst_d = 1'b0;
            end
            CMD_STEP: begin
              state_d    = ST_STEP;
              dut_ce_d   = 1'b1;
              step_cnt_d = '0;
            end
            CMD_LOAD: begin
              state_d    = ST_LOAD;
              load_cnt_d = '0;
            end
            default: begin
              state_d    = ST_ERR;
              err_d      = 1'b1;
              err_code_d = cmd_rsp.cmd_data;
            end
          endcase
        end
      end

      ST_LOAD: begin
        if (cmd_fire_c) begin
          shadow_d = load_shift_c;
          if (load_cnt_q == LOAD_CNT_W'(INPUT_BYTES - 1)) begin
            dut_in_d   = load_shift_c;
            load_cnt_d = '0;
            state_d    = ST_IDLE;
          end else begin
            load_cnt_d = load_cnt_q + LOAD_CNT_W'(1);
          end
        end
      end

      // dut_ce_q is already high for this cycle; decide whether to keep it.
      ST_STEP: begin
        if (step_cnt_q == STEP_CNT_W'(STEP_CYCLES - 1)) begin
          step_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          dut_ce_d   = 1'b1;
          step_cnt_d = step_cnt_q + STEP_CNT_W'(1);
        end
      end

      ST_DUMP: begin
        if (rsp_fire_c) begin
          if (dump_cnt_q == DUMP_CNT_W'(RSP_WORDS - 1)) begin
            rsp_valid_d = 1'b0;
            dump_cnt_d  = '0;
            state_d     = ST_IDLE;
          end else begin
            dump_cnt_d = dump_cnt_q + DUMP_CNT_W'(1);
            snap_d     = snap_shift_c;
            rsp_data_d = snap_shift_c[31:0];
          end
        end
      end

      ST_HALT: ;
      ST_ERR:  ;
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_rsp.cmd_ready = cmd_ready_c;
  assign cmd_rsp.rsp_valid = rsp_valid_q;
  assign cmd_rsp.rsp_data  = rsp_data_q;
  assign dut_in_o          = dut_in_q;
  assign dut_rst_o         = dut_rst_q;
  assign dut_ce_o          = dut_ce_q;
  assign done_o            = done_q;
  assign err_o             = err_q;
  assign err_code_o        = err_code_q;
`ifdef STEP_COUNT_EN
  assign step_count_o      = step_count_q;
`endif

endmodule
